mc_control_fsm: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, register file, instruction register and unified memory through fetch, decode, execute and writeback.
- Drives the ALU's ALUControl encoding directly and consumes its Zero flag.
- Adds a memory ready handshake with timeout.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_control_fsm_if.sv | 50 +++++
 rtl/alu_decoder.sv | 39 +++
 rtl/mc_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and encodings for the multicycle RV32I control path:
//   state_t   - main control FSM states
//   OP_*      - supported major opcodes
//   ALU_*     - ALUControl encodings driven to the shared ALU
//   alu_op_t  - coarse ALU operation requested by the FSM
//   IMM_*, RES_*, SRCA_*, SRCB_* - datapath mux select encodings
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the control FSM and the multicycle datapath.
//   Datapath -> control : op, funct3, funct7b5, Zero, MemReady
//   Control -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//                         ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl,
//                         IllegalInstr, BusErr (+ InstRet when
//                         MC_CTRL_INSTRET_EN is defined)
// Modports: master = control FSM, slave = datapath.
// ----------------------------------------------------------------------------
interface mc_control_fsm_if;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic        IllegalInstr;
  logic        BusErr;
`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] InstRet;
`endif

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, IllegalInstr, BusErr
`ifdef MC_CTRL_INSTRET_EN
    , output InstRet
`endif
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, IllegalInstr, BusErr
`ifdef MC_CTRL_INSTRET_EN
    , input InstRet
`endif
  );
endinterface

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's coarse ALU request into the ALU's
// 3-bit ALUControl code.
//   i_alu_op     : add / sub / decode-from-funct
//   i_funct3     : instruction funct3
//   i_op5        : opcode bit 5 (1 for R-type, 0 for I-type ALU)
//   i_funct7b5   : instruction bit 30
//   o_alu_control: ALUControl encoding
// ----------------------------------------------------------------------------
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    unique case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      default: begin
        case (i_funct3)
          // Only R-type can subtract; addi reuses bit 30 as immediate data.
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory access and writeback over a shared ALU and unified memory,
// with a MemReady handshake and a configurable memory wait timeout.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high, forces FETCH
//   bus      : mc_control_fsm_if.master (instruction fields, Zero, MemReady
//              in; datapath controls, IllegalInstr, BusErr out)
// Parameter MEM_TIMEOUT : MemReady-low cycles tolerated in a memory state
//              before abort (0 = wait forever).
// Optional  : define MC_CTRL_INSTRET_EN to add the 32-bit retired-instruction
//              counter bus.InstRet.
// ----------------------------------------------------------------------------
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus
);

  localparam logic [31:0] TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_wait_cnt;
  logic [31:0] w_wait_next;
  logic        w_mem_wait;
  logic        w_timeout;
  alu_op_t     w_alu_op;
  logic [2:0]  w_alu_control;

  // Memory-access states that wait on MemReady and are covered by the timeout.
  assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWRITE);

  // Timeout fires in the cycle the counter would reach MEM_TIMEOUT; a
  // completing MemReady in that same cycle takes priority.
  assign w_timeout = (MEM_TIMEOUT != 0) && !reset && w_mem_wait &&
                     !bus.MemReady && (r_wait_cnt == TIMEOUT_LAST);

  // Counter only runs while stalled; any completion, abort or state change
  // (which only happens on completion/abort here) clears it.
  assign w_wait_next = (w_mem_wait && !bus.MemReady && !w_timeout) ?
                       r_wait_cnt + 32'd1 : 32'd0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)         w_state_next = S_FETCH;
        else if (bus.MemReady) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_R:         w_state_next = S_EXECUTER;
          OP_I:         w_state_next = S_EXECUTEI;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_JAL:       w_state_next = S_JAL;
          default:      w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (w_timeout)         w_state_next = S_FETCH;
        else if (bus.MemReady) w_state_next = S_MEMWB;
      end
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: begin
        if (w_timeout || bus.MemReady) w_state_next = S_FETCH;
      end
      S_EXECUTER: w_state_next = S_ALUWB;
      S_EXECUTEI: w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BEQ:      w_state_next = S_FETCH;
      S_JAL:      w_state_next = S_ALUWB;
      default:    w_state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_op5         (bus.op[5]),
    .i_funct7b5    (bus.funct7b5),
    .o_alu_control (w_alu_control)
  );

  assign bus.ALUControl = w_alu_control;
  assign bus.BusErr     = w_timeout;

  // Output decode
  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.ResultSrc    = RES_ALUOUT;
    bus.ALUSrcA      = SRCA_PC;
    bus.ALUSrcB      = SRCB_RS2;
    bus.RegWrite     = 1'b0;
    bus.IllegalInstr = 1'b0;
    w_alu_op         = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        // Reset holds the FSM in FETCH; keep the write strobes quiet then.
        bus.IRWrite   = bus.MemReady && !reset;
        bus.PCWrite   = bus.MemReady && !reset;
      end
      S_DECODE: begin
        bus.ALUSrcA      = SRCA_OLDPC;
        bus.ALUSrcB      = SRCB_IMM;
        bus.IllegalInstr = !is_supported_op(bus.op);
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        w_alu_op    = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        w_alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        w_alu_op    = ALUOP_SUB;
        bus.PCWrite = bus.Zero;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  // Last cycle of each retiring instruction; JAL retires through ALUWB.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && bus.MemReady);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign bus.InstRet = r_instret;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3,
                 T_MEMWB = 4, T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7,
                 T_ALUWB = 8, T_BEQ = 9, T_JAL = 10;

  localparam logic [6:0] C_LW = 7'b0000011, C_SW = 7'b0100011, C_R = 7'b0110011,
                         C_I = 7'b0010011, C_BEQ = 7'b1100011, C_JAL = 7'b1101111,
                         C_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_v;
  logic [17:0] obs;
`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] exp_instret = 32'd0;
`endif

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl,
                bus.IllegalInstr, bus.BusErr};

  function automatic logic [2:0] func_alu(input logic op5, input logic f7b5, input logic [2:0] f3);
    case (f3)
      3'b000:  return (op5 && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector from the per-state control table.
  function automatic logic [17:0] model(input int st, input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7b5, input logic zero, input logic mr,
                                        input logic berr);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sbv, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sbv = 2'b00; alu = 3'b000;
    imm = (op == C_SW) ? 2'b01 : (op == C_BEQ) ? 2'b10 : (op == C_JAL) ? 2'b11 : 2'b00;
    case (st)
      T_FETCH:    begin sbv = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      T_DECODE:   begin sa = 2'b01; sbv = 2'b01;
                        ill = !(op == C_LW || op == C_SW || op == C_R || op == C_I ||
                                op == C_BEQ || op == C_JAL); end
      T_MEMADR:   begin sa = 2'b10; sbv = 2'b01; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin rs = 2'b01; rw = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; end
      T_EXECR:    begin sa = 2'b10; sbv = 2'b00; alu = func_alu(op[5], f7b5, f3); end
      T_EXECI:    begin sa = 2'b10; sbv = 2'b01; alu = func_alu(op[5], f7b5, f3); end
      T_ALUWB:    rw = 1;
      T_BEQ:      begin sa = 2'b10; sbv = 2'b00; alu = 3'b001; pcw = zero; end
      T_JAL:      begin sa = 2'b01; sbv = 2'b10; pcw = 1; end
      default:    ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sbv, rw, imm, alu, ill, berr};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7b5;
  endtask

  // One clock of stimulus: push expectation, compare at the falling edge.
  task automatic step(input string tag, input int st, input logic mr, input logic zero,
                      input logic berr);
    bus.MemReady = mr;
    bus.Zero     = zero;
    exp_q.push_back(model(st, bus.op, bus.funct3, bus.funct7b5, zero, mr, berr));
`ifdef MC_CTRL_INSTRET_EN
    if (st == T_MEMWB || st == T_ALUWB || st == T_BEQ || (st == T_MEMWRITE && mr))
      exp_instret = exp_instret + 32'd1;
`endif
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
    $display("step %-10s st=%0d mr=%0b obs=%h exp=%h", tag, st, mr, obs, exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_instret(input string tag);
`ifdef MC_CTRL_INSTRET_EN
    checks++;
    assert (bus.InstRet === exp_instret) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, bus.InstRet, exp_instret);
    end
    $display("instret %-10s obs=%0d exp=%0d", tag, bus.InstRet, exp_instret);
`else
    $display("instret %-10s not built", tag);
`endif
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7b5);
    set_instr(op, f3, f7b5);
    step({tag, "_f"}, T_FETCH, 1'b1, 1'b0, 1'b0);
    step({tag, "_d"}, T_DECODE, 1'b1, 1'b0, 1'b0);
    step({tag, "_x"}, (op == C_R) ? T_EXECR : T_EXECI, 1'b1, 1'b0, 1'b0);
    step({tag, "_wb"}, T_ALUWB, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    bus.MemReady = 1'b1;

    // Reset: FETCH decode with strobes suppressed although MemReady is high.
    repeat (2) @(posedge clk);
    exp_q.push_back(model(T_FETCH, bus.op, bus.funct3, bus.funct7b5, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL reset obs=%h exp=%h", obs, exp_v);
    end
    $display("step reset      obs=%h exp=%h", obs, exp_v);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_instret("after_rst");

    alu_instr("add", C_R, 3'b000, 1'b0);
    check_instret("add");
    alu_instr("sub", C_R, 3'b000, 1'b1);
    alu_instr("addi", C_I, 3'b000, 1'b1);
    alu_instr("slt", C_R, 3'b010, 1'b0);
    alu_instr("ori", C_I, 3'b110, 1'b0);
    alu_instr("and", C_R, 3'b111, 1'b0);
    alu_instr("f3_001", C_R, 3'b001, 1'b1);
    check_instret("alu7");

    // lw with three stalled MEMREAD cycles
    set_instr(C_LW, 3'b010, 1'b0);
    step("lw_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("lw_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("lw_ma", T_MEMADR, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("lw_rd_wait", T_MEMREAD, 1'b0, 1'b0, 1'b0);
    step("lw_rd", T_MEMREAD, 1'b1, 1'b0, 1'b0);
    step("lw_wb", T_MEMWB, 1'b1, 1'b0, 1'b0);

    // beq taken and not taken
    set_instr(C_BEQ, 3'b000, 1'b0);
    step("beq1_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("beq1_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("beq1_x", T_BEQ, 1'b1, 1'b1, 1'b0);
    step("beq0_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("beq0_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("beq0_x", T_BEQ, 1'b1, 1'b0, 1'b0);

    // jal
    set_instr(C_JAL, 3'b000, 1'b0);
    step("jal_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("jal_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("jal_x", T_JAL, 1'b1, 1'b0, 1'b0);
    step("jal_wb", T_ALUWB, 1'b1, 1'b0, 1'b0);
    check_instret("jal");

    // sw with MemReady stuck low: timeout on the fourth MEMWRITE cycle
    set_instr(C_SW, 3'b010, 1'b0);
    step("swto_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("swto_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("swto_ma", T_MEMADR, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("swto_wait", T_MEMWRITE, 1'b0, 1'b0, 1'b0);
    step("swto_berr", T_MEMWRITE, 1'b0, 1'b0, 1'b1);
    check_instret("sw_abort");

    // sw completing in the fourth cycle: completion wins
    step("swok_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("swok_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("swok_ma", T_MEMADR, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("swok_wait", T_MEMWRITE, 1'b0, 1'b0, 1'b0);
    step("swok_done", T_MEMWRITE, 1'b1, 1'b0, 1'b0);
    check_instret("sw_ok");

    // Fetch timeout: no IRWrite/PCWrite for the aborted access
    for (int i = 0; i < 3; i++) step("fto_wait", T_FETCH, 1'b0, 1'b0, 1'b0);
    step("fto_berr", T_FETCH, 1'b0, 1'b0, 1'b1);

    // Illegal opcode
    set_instr(C_BAD, 3'b000, 1'b0);
    step("ill_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("ill_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    step("ill_back", T_FETCH, 1'b0, 1'b0, 1'b0);
    check_instret("illegal");

    // Asynchronous reset in the middle of an instruction
    set_instr(C_R, 3'b000, 1'b0);
    step("mid_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    bus.MemReady = 1'b1;
    reset = 1'b1;
    #1;
    exp_v = model(T_FETCH, bus.op, bus.funct3, bus.funct7b5, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL mid_reset obs=%h exp=%h", obs, exp_v);
    end
    $display("step mid_reset  obs=%h exp=%h", obs, exp_v);
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef MC_CTRL_INSTRET_EN
    exp_instret = 32'd0;
`endif
    check_instret("mid_reset");

    // Three ALU instructions plus one illegal
    alu_instr("r1", C_R, 3'b000, 1'b0);
    alu_instr("r2", C_I, 3'b111, 1'b0);
    alu_instr("r3", C_R, 3'b110, 1'b0);
    set_instr(C_BAD, 3'b000, 1'b0);
    step("ill2_f", T_FETCH, 1'b1, 1'b0, 1'b0);
    step("ill2_d", T_DECODE, 1'b1, 1'b0, 1'b0);
    check_instret("three_alu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
